// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8) helpers
// Purpose: FSM state enum, round count, block width, the rcon table, and
// forward plus inverse round helpers shared by the encrypt and decrypt cores.
// State byte i sits at bits [127-8*i -: 8]; byte i is row i%4, column i/4.
package aes_pkg;

    typedef enum logic {IDLE, ROUND} state_t;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;

    // Round constant for rounds 1..10; 0 outside that range.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = a;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09),
                gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d),
                gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b),
                gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e)};
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_encrypt_core_if.sv
// rtl/aes_encrypt_core_if.sv - start/ready/done handshake bundle for the encrypt core
// Purpose: groups the request, operand and result signals of aes_encrypt_core.
// Signals: start, key_in, text_in (host -> core); ready, done, result (core -> host);
// last_key (core -> host) only when AES_ENC_LASTKEY_EN is defined.
// Modports: master (host side), slave (core side).
interface aes_encrypt_core_if;
    import aes_pkg::*;

    logic               start;
    logic [BLOCK_W-1:0] key_in;
    logic [BLOCK_W-1:0] text_in;
    logic               ready;
    logic               done;
    logic [BLOCK_W-1:0] result;

`ifdef AES_ENC_LASTKEY_EN
    logic [BLOCK_W-1:0] last_key;

    modport master (output start, key_in, text_in, input ready, done, result, last_key);
    modport slave  (input start, key_in, text_in, output ready, done, result, last_key);
`else
    modport master (output start, key_in, text_in, input ready, done, result);
    modport slave  (input start, key_in, text_in, output ready, done, result);
`endif

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box
// Purpose: S(a) = affine(a^-1) over GF(2^8).
// Ports: i_a (8-bit input byte), o_s (8-bit substituted byte).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);

    logic [7:0] w_inv;

    assign w_inv = gf_inv(i_a);

    // Affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    assign o_s = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128 encryption, one round per clock
// Purpose: encrypts one block in 11 edges with an on-the-fly key schedule.
// Ports: clk (rising edge), rst (async, active-low),
//        bus (aes_encrypt_core_if.slave: start/key_in/text_in in, ready/done/result out).
// Config: AES_ENC_LASTKEY_EN adds bus.last_key, the round-10 key captured with result.
module aes_encrypt_core
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    aes_encrypt_core_if.slave   bus
);

    state_t             r_fsm;
    logic [BLOCK_W-1:0] r_state;
    logic [BLOCK_W-1:0] r_rkey;
    logic [BLOCK_W-1:0] r_result;
    logic [3:0]         r_round;
    logic               r_ready;
    logic               r_done;
`ifdef AES_ENC_LASTKEY_EN
    logic [BLOCK_W-1:0] r_last_key;
`endif

    logic [BLOCK_W-1:0] w_sub;
    logic [BLOCK_W-1:0] w_sr;
    logic [BLOCK_W-1:0] w_mc;
    logic [BLOCK_W-1:0] w_next_state;
    logic [BLOCK_W-1:0] w_next_key;
    logic [31:0]        w_rot;
    logic [31:0]        w_subw;
    logic [31:0]        w_temp;
    logic               w_last_round;

    // SubBytes over the whole state.
    for (genvar g = 0; g < 16; g++) begin : g_sub
        aes_sbox u_sbox (.i_a(r_state[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
    end

    // SubWord(RotWord(w3)) for the key schedule.
    assign w_rot = {r_rkey[23:0], r_rkey[31:24]};
    for (genvar g = 0; g < 4; g++) begin : g_subw
        aes_sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_s(w_subw[8*g +: 8]));
    end

    assign w_temp                = w_subw ^ {rcon(r_round), 24'h000000};
    assign w_next_key[127:96]    = r_rkey[127:96] ^ w_temp;
    assign w_next_key[95:64]     = r_rkey[95:64]  ^ w_next_key[127:96];
    assign w_next_key[63:32]     = r_rkey[63:32]  ^ w_next_key[95:64];
    assign w_next_key[31:0]      = r_rkey[31:0]   ^ w_next_key[63:32];

    assign w_sr = shift_rows(w_sub);
    assign w_mc = {mix_column(w_sr[127:96]), mix_column(w_sr[95:64]),
                   mix_column(w_sr[63:32]),  mix_column(w_sr[31:0])};

    assign w_last_round = (r_round == 4'(NR));
    assign w_next_state = (w_last_round ? w_sr : w_mc) ^ w_next_key;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm      <= IDLE;
            r_state    <= '0;
            r_rkey     <= '0;
            r_result   <= '0;
            r_round    <= 4'd0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
`ifdef AES_ENC_LASTKEY_EN
            r_last_key <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= bus.text_in ^ bus.key_in;
                        r_rkey  <= bus.key_in;
                        r_round <= 4'd1;
                        r_ready <= 1'b0;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    r_state <= w_next_state;
                    r_rkey  <= w_next_key;
                    r_round <= r_round + 4'd1;
                    if (w_last_round) begin
                        r_result   <= w_next_state;
`ifdef AES_ENC_LASTKEY_EN
                        r_last_key <= w_next_key;
`endif
                        r_done     <= 1'b1;
                        r_ready    <= 1'b1;
                        r_round    <= 4'd0;
                        r_fsm      <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.done   = r_done;
    assign bus.result = r_result;
`ifdef AES_ENC_LASTKEY_EN
    assign bus.last_key = r_last_key;
`endif

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - self-checking bench for aes_encrypt_core
module tb_aes_encrypt_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_encrypt_core_if bus_if();
    aes_encrypt_core dut (.clk(clk), .rst(rst), .bus(bus_if));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [7:0]   rct [11];
    logic [31:0]  kw  [44];
    logic [127:0] seen_lk;

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LKB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // GF(2^8) product by carry-less multiply then polynomial reduction mod 0x11b.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            logic [7:0] b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[a]  = b;
            isb[b] = 8'(a);
        end
        c = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            rct[k] = c;
            c = gm(c, 8'h02);
        end
    endtask

    function automatic logic [31:0] subrot(input logic [31:0] t, input int k);
        return {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rct[k], 24'h0};
    endfunction

    task automatic expand_key(input logic [127:0] key);
        for (int i = 0; i < 4; i++) kw[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++)
            kw[i] = kw[i-4] ^ ((i % 4 == 0) ? subrot(kw[i-1], i/4) : kw[i-1]);
    endtask

    task automatic unexpand_key(input logic [127:0] lk);
        for (int i = 0; i < 4; i++) kw[40+i] = lk[127-32*i -: 32];
        for (int i = 43; i >= 4; i--)
            kw[i-4] = kw[i] ^ ((i % 4 == 0) ? subrot(kw[i-1], i/4) : kw[i-1]);
    endtask

    function automatic logic [7:0] rkb(input int r, input int j);
        return kw[4*r + j/4][31-8*(j%4) -: 8];
    endfunction

    task automatic ref_enc(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output logic [127:0] lk);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        expand_key(key);
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ rkb(0, j);
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sb[s[j]];
            for (int w = 0; w < 4; w++)
                for (int c = 0; c < 4; c++) s[w+4*c] = t[w+4*((c+w)%4)];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                    s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
                end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ rkb(r, j);
        end
        for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = s[j];
        lk = {kw[40], kw[41], kw[42], kw[43]};
    endtask

    task automatic ref_dec(input logic [127:0] lk, input logic [127:0] ct,
                           output logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        unexpand_key(lk);
        for (int j = 0; j < 16; j++) s[j] = ct[127-8*j -: 8] ^ rkb(10, j);
        for (int r = 9; r >= 0; r--) begin
            for (int w = 0; w < 4; w++)
                for (int c = 0; c < 4; c++) t[w+4*c] = s[w+4*((c+4-w)%4)];
            for (int j = 0; j < 16; j++) s[j] = isb[t[j]] ^ rkb(r, j);
            if (r > 0)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
                    s[4*c+1] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
                    s[4*c+2] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
                    s[4*c+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
                end
        end
        for (int j = 0; j < 16; j++) pt[127-8*j -: 8] = s[j];
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issues one start and waits (bounded) for done; scrambles inputs while busy.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             output logic [127:0] res, output int edges,
                             output logic got, output logic busy_ok, output logic rdy);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.key_in = key; bus_if.text_in = pt;
        edges = 0; got = 1'b0; busy_ok = 1'b1; res = '0; rdy = 1'b0;
        while (!got && edges < 30) begin
            @(negedge clk);
            edges++;
            bus_if.start = 1'b0;
            bus_if.key_in = rnd128(); bus_if.text_in = rnd128();
            if (bus_if.done === 1'b1) begin
                got = 1'b1; res = bus_if.result; rdy = bus_if.ready;
`ifdef AES_ENC_LASTKEY_EN
                seen_lk = bus_if.last_key;
`endif
            end else if (bus_if.ready !== 1'b0) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus_if.start = 1'b0; bus_if.key_in = '0; bus_if.text_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus_if.ready); end
        n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus_if.done); end
        n_cmp++; if (bus_if.result !== '0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus_if.result); end
`ifdef AES_ENC_LASTKEY_EN
        n_cmp++; if (bus_if.last_key !== '0) begin n_bad++; $display("FAIL reset_last_key got %h want 0", bus_if.last_key); end
`endif
        rst = 1'b1;
    endtask

    task automatic test_vector(input logic [127:0] key, input logic [127:0] pt,
                               input logic [127:0] exp, input string nm);
        logic [127:0] res, mct, mlk, lk_src, back;
        int edges;
        logic got, busy_ok, rdy;
        ref_enc(key, pt, mct, mlk);
        run_block(key, pt, res, edges, got, busy_ok, rdy);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL %s_done got %b want 1", nm, got); end
        n_cmp++; if (edges != 11) begin n_bad++; $display("FAIL %s_latency got %0d want 11", nm, edges); end
        n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL %s_result got %h want %h", nm, res, exp); end
        n_cmp++; if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL %s_busy_ready got ready!=0 want 0", nm); end
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL %s_ready_at_done got %b want 1", nm, rdy); end
        lk_src = mlk;
`ifdef AES_ENC_LASTKEY_EN
        n_cmp++; if (seen_lk !== mlk) begin n_bad++; $display("FAIL %s_last_key got %h want %h", nm, seen_lk, mlk); end
        lk_src = seen_lk;
`endif
        ref_dec(lk_src, res, back);
        n_cmp++; if (back !== pt) begin n_bad++; $display("FAIL %s_roundtrip got %h want %h", nm, back, pt); end
        @(negedge clk);
        n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse got %b want 0", nm, bus_if.done); end
        n_cmp++; if (bus_if.result !== exp) begin n_bad++; $display("FAIL %s_result_hold got %h want %h", nm, bus_if.result, exp); end
    endtask

    task automatic test_fips_b;
        test_vector(KB, PB, CB, "fips_b");
`ifdef AES_ENC_LASTKEY_EN
        n_cmp++; if (seen_lk !== LKB) begin n_bad++; $display("FAIL fips_b_last_key got %h want %h", seen_lk, LKB); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [127:0] r1, r2;
        int e1, e2;
        logic d1, d2, rdy;
        r1 = '0; r2 = '0; rdy = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.key_in = '0; bus_if.text_in = '0;
        e1 = 0; d1 = 1'b0;
        while (!d1 && e1 < 30) begin
            @(negedge clk); e1++;
            if (bus_if.done === 1'b1) begin d1 = 1'b1; r1 = bus_if.result; rdy = bus_if.ready; end
        end
        bus_if.key_in = KC; bus_if.text_in = PC;
        e2 = 0; d2 = 1'b0;
        while (!d2 && e2 < 30) begin
            @(negedge clk); e2++;
            bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) begin d2 = 1'b1; r2 = bus_if.result; end
        end
        n_cmp++; if (e1 != 11) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 11", e1); end
        n_cmp++; if (r1 !== CZ) begin n_bad++; $display("FAIL b2b_zero_result got %h want %h", r1, CZ); end
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_done got %b want 1", rdy); end
        n_cmp++; if (e2 != 11) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 11", e2); end
        n_cmp++; if (r2 !== CC) begin n_bad++; $display("FAIL b2b_second_result got %h want %h", r2, CC); end
    endtask

    task automatic test_ignore_busy;
        logic [127:0] key, pt, exp, lk, res;
        int ndone, first;
        key = rnd128(); pt = rnd128();
        ref_enc(key, pt, exp, lk);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.key_in = key; bus_if.text_in = pt;
        ndone = 0; first = 0; res = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin ndone++; res = bus_if.result; first = k; end
            bus_if.start = (k < 11);
            bus_if.text_in = rnd128();
        end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL busy_done_count got %0d want 1", ndone); end
        n_cmp++; if (first != 11) begin n_bad++; $display("FAIL busy_latency got %0d want 11", first); end
        n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL busy_result got %h want %h", res, exp); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.key_in = rnd128(); bus_if.text_in = rnd128();
        repeat (5) begin @(negedge clk); bus_if.start = 1'b0; end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", bus_if.ready); end
        n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", bus_if.done); end
        n_cmp++; if (bus_if.result !== '0) begin n_bad++; $display("FAIL midrst_result got %h want 0", bus_if.result); end
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        repeat (15) begin @(negedge clk); if (bus_if.done === 1'b1) ndone++; end
        n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL midrst_late_done got %0d want 0", ndone); end
    endtask

    task automatic test_random;
        logic [127:0] key, pt, exp, lk;
        for (int i = 0; i < 6; i++) begin
            key = rnd128(); pt = rnd128();
            ref_enc(key, pt, exp, lk);
            test_vector(key, pt, exp, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        seen_lk = '0;
        build_tables();
        test_reset();
        test_fips_b();
        test_vector(KC, PC, CC, "fips_c1");
        test_vector('0, '0, CZ, "zero");
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

Iterative AES-128 encryption core. It computes one round per clock and expands the key schedule on the fly. It is the forward-direction counterpart of the decryption datapath in the same crypto subsystem, and produces ciphertext that the decryption core accepts as input. A start/ready/done handshake controls it, so a host FSM can stream blocks back-to-back.

## Interface
Parameters: none. The core is AES-128 only (Nk=4, Nr=10).

- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request to encrypt; sampled only while ready=1
- key_in  input  128  cipher key; bits [127:120] = FIPS-197 key byte 0
- text_in  input  128  plaintext block; bits [127:120] = state byte 0 (column-major)
- ready  output  1  core idle and able to accept start
- done  output  1  single-cycle pulse; result valid
- result  output  128  ciphertext; holds its value until the next completion
- last_key  output  128  round-10 key; present only with AES_ENC_LASTKEY_EN

## Operation
- States: IDLE, ROUND.
- IDLE, start=1 at an edge:
  - state_reg <= text_in ^ key_in (initial AddRoundKey)
  - rkey_reg <= key_in
  - round_cnt <= 1
  - go to ROUND; ready drops.
- ROUND, at each edge:
  - next_key = KeyExpand(rkey_reg, rcon[round_cnt]), i.e. RotWord, SubWord, XOR rcon, then the XOR chain across the four words.
  - state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_key. When round_cnt=10, MixColumns is skipped.
  - rkey_reg <= next_key; round_cnt <= round_cnt+1.
- At round_cnt=10:
  - result <= final state; done <= 1 for one cycle.
  - Return to IDLE; ready <= 1.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
- MixColumns uses xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). All arithmetic is GF(2^8); no carries.
- key_in and text_in are sampled only at the accepting edge. Changes while busy have no effect.
- start while ready=0 is ignored, not queued.

## Timing
- Reset (rst=0, asynchronous): ready=1, done=0, result=0, last_key=0, state IDLE, round_cnt=0, internal registers 0.
- Reset asserted mid-operation aborts immediately. No done is produced, and the prior result is cleared to 0.
- Latency: start accepted at edge T, then done=1 and result valid in the cycle after edge T+10. That is 11 edges in total.
- ready=0 from after edge T through edge T+9. ready returns to 1 at edge T+10, in the same cycle that done=1.
- Back-to-back: start=1 in the done cycle is accepted at that edge, giving 11-cycle throughput with no bubble.
- done never lasts more than one cycle. result changes only at the edge that raises done.

## Configuration
- AES_ENC_LASTKEY_EN defined:
  - Port last_key is present.
  - last_key <= round-10 key at the same edge as result. It is the starting key the decryption core needs.
- AES_ENC_LASTKEY_EN undefined: the port and its register are absent, with no other behavioural change.

## Structure
- Shared package aes_pkg holds:
  - the state enum (IDLE, ROUND)
  - the rcon table
  - constants NR=10 and BLOCK_W=128
  - functions xtime, mix_column, shift_rows
- The inverse-direction functions already used by decryption belong in the same package.
- One sub-module, aes_sbox: combinational 8-bit forward S-box lookup.
  - 16 instances for SubBytes.
  - 4 instances for SubWord in the key schedule.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> result 3925841d02dc09fbdc118597196a0b32, done exactly 11 edges after start. With the macro, last_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Then start held high across the done cycle with the App. C.1 vectors -> second done exactly 11 cycles later with the correct value.
- start pulsed every cycle while busy, with text_in toggling -> ignored. Single done, result equal to the originally sampled block.
- rst=0 at round 5 -> ready=1, done=0, result=0 immediately with no clock edge. No done appears afterward.
- Round-trip: feed result and last_key into the decryption core -> original plaintext recovered for all three vectors.
